// File: rtl/ram_pkg.sv
// Shared definitions for the triggered capture/readout buffer: FSM state encoding and depth helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  // Number of RAM entries for a given address width.
  function automatic int depth(input int nbits);
    return 1 << nbits;
  endfunction

endpackage

// File: rtl/ram_trig_readout_if.sv
// Readout stream of the trigger buffer: valid/ready with a last-beat marker.
// Latency: n/a (interface).
// Backpressure: producer holds data/last while valid is high and ready is low.
interface ram_trig_readout_if #(
  parameter int P_NBITS_DATA = 14
) ();

  logic                    rd_valid;
  logic                    rd_ready;
  logic [P_NBITS_DATA-1:0] rd_data;
  logic                    rd_last;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);

endinterface

// File: rtl/ram_dual.sv
// Simple dual-port RAM: one write port, one read port, same clock.
// Latency: 1 cycle read; the read register holds its value while rd_en is low.
// Backpressure: none; the caller stalls by withholding rd_en.
module ram_dual
  import ram_pkg::*;
#(
  parameter int P_NBITS_ADDR = 8,
  parameter int P_NBITS_DATA = 14
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [P_NBITS_ADDR-1:0] wr_addr,
  input  logic [P_NBITS_DATA-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [P_NBITS_ADDR-1:0] rd_addr,
  output logic [P_NBITS_DATA-1:0] rd_data
);

  localparam int DEPTH = depth(P_NBITS_ADDR);

  logic [P_NBITS_DATA-1:0] mem [DEPTH];
  logic [P_NBITS_DATA-1:0] rd_data_q;

  // Storage array and registered read; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_trig_readout.sv
// Pre-trigger circular capture buffer; after trig + post_len samples it streams the window oldest-first.
// Latency: first beat 2 cycles after capture ends, then 1 beat/cycle; done pulses 1 cycle after the last beat.
// Backpressure: rd_ready low stalls the read pipe, output held stable. Build option: RAM_TRIG_READOUT_RETRIG_EN.
module ram_trig_readout
  import ram_pkg::*;
#(
  parameter int P_NBITS_ADDR = 8,
  parameter int P_NBITS_DATA = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    wr,
  input  logic [P_NBITS_DATA-1:0] d,
  input  logic                    trig,
  input  logic [P_NBITS_ADDR-1:0] pre_len,
  input  logic [P_NBITS_ADDR-1:0] post_len,
  ram_trig_readout_if.master      rd,
  output logic                    busy,
  output logic                    done
);

`ifdef RAM_TRIG_READOUT_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  // Largest pre+post span; the window is kept one short of the depth.
  localparam logic [P_NBITS_ADDR-1:0] MAX_SPAN = P_NBITS_ADDR'(depth(P_NBITS_ADDR) - 2);

  state_t                  state_q, state_d;
  logic [P_NBITS_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [P_NBITS_ADDR-1:0] fill_q, fill_d;
  logic [P_NBITS_ADDR-1:0] pre_lat_q, pre_lat_d;
  logic [P_NBITS_ADDR-1:0] post_lat_q, post_lat_d;
  logic [P_NBITS_ADDR-1:0] t_addr_q, t_addr_d;
  logic [P_NBITS_ADDR-1:0] post_cnt_q, post_cnt_d;
  logic [P_NBITS_ADDR-1:0] post_tot_q, post_tot_d;
  logic [P_NBITS_ADDR-1:0] rd_cnt_q, rd_cnt_d;
  logic                    ram_vld_q, ram_vld_d;
  logic                    ram_last_q, ram_last_d;
  logic                    out_vld_q, out_vld_d;
  logic [P_NBITS_DATA-1:0] out_dat_q, out_dat_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;

  logic                    we;
  logic                    issue;
  logic                    load_out;
  logic                    beat_done;
  logic [P_NBITS_ADDR-1:0] post_room;
  logic [P_NBITS_ADDR-1:0] post_eff;
  logic [P_NBITS_ADDR-1:0] pre_clamp;
  logic [P_NBITS_ADDR-1:0] win_len;
  logic [P_NBITS_ADDR-1:0] rd_addr;
  logic [P_NBITS_DATA-1:0] ram_rdata;

  // Datapath decodes: write gating, window geometry, read pipe handshakes.
  always_comb begin
    we        = wr && (state_q == ST_ARMED || state_q == ST_POST);
    pre_clamp = (pre_len > MAX_SPAN) ? MAX_SPAN : pre_len;
    post_room = MAX_SPAN - pre_lat_q;
    post_eff  = (post_len > post_room) ? post_room : post_len;
    win_len   = pre_lat_q + post_tot_q + 1'b1;
    rd_addr   = t_addr_q - pre_lat_q + rd_cnt_q;
    beat_done = out_vld_q && rd.rd_ready;
    // RAM read register acts as a second stage, so streaming has no bubbles.
    load_out  = ram_vld_q && (!out_vld_q || rd.rd_ready);
    issue     = (state_q == ST_READ) && (rd_cnt_q != win_len) && (!ram_vld_q || load_out);
  end

  // Next-state for the control FSM, counters and output register.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    fill_d     = fill_q;
    pre_lat_d  = pre_lat_q;
    post_lat_d = post_lat_q;
    t_addr_d   = t_addr_q;
    post_cnt_d = post_cnt_q;
    post_tot_d = post_tot_q;
    rd_cnt_d   = rd_cnt_q;
    ram_vld_d  = ram_vld_q;
    ram_last_d = ram_last_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;

    if (we) wr_addr_d = wr_addr_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d   = ST_ARMED;
          pre_lat_d = pre_clamp;
          fill_d    = '0;
        end
      end
      ST_ARMED: begin
        if (wr) begin
          if (trig && fill_q == pre_lat_q) begin
            t_addr_d   = wr_addr_q;
            post_lat_d = post_eff;
            post_cnt_d = '0;
            post_tot_d = '0;
            rd_cnt_d   = '0;
            state_d    = (post_eff == '0) ? ST_READ : ST_POST;
          end else if (fill_q != pre_lat_q) begin
            fill_d = fill_q + 1'b1;
          end
        end
      end
      ST_POST: begin
        if (wr) begin
          post_tot_d = post_tot_q + 1'b1;
          if (RETRIG && trig) begin
            // Retrigger: need post_lat more samples after this one, within the span cap.
            post_cnt_d = '0;
            if (post_tot_q + 1'b1 == post_room) state_d = ST_READ;
          end else begin
            post_cnt_d = post_cnt_q + 1'b1;
            if (post_cnt_q + 1'b1 == post_lat_q || post_tot_q + 1'b1 == post_room)
              state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (beat_done && out_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      rd_cnt_d   = rd_cnt_q + 1'b1;
      ram_last_d = (rd_cnt_q + 1'b1 == win_len);
    end

    if (issue)         ram_vld_d = 1'b1;
    else if (load_out) ram_vld_d = 1'b0;

    if (load_out) begin
      out_vld_d  = 1'b1;
      out_dat_d  = ram_rdata;
      out_last_d = ram_last_q;
    end else if (beat_done) begin
      out_vld_d = 1'b0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      fill_q     <= '0;
      pre_lat_q  <= '0;
      post_lat_q <= '0;
      t_addr_q   <= '0;
      post_cnt_q <= '0;
      post_tot_q <= '0;
      rd_cnt_q   <= '0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      fill_q     <= fill_d;
      pre_lat_q  <= pre_lat_d;
      post_lat_q <= post_lat_d;
      t_addr_q   <= t_addr_d;
      post_cnt_q <= post_cnt_d;
      post_tot_q <= post_tot_d;
      rd_cnt_q   <= rd_cnt_d;
      ram_vld_q  <= ram_vld_d;
      ram_last_q <= ram_last_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
    end
  end

  ram_dual #(
    .P_NBITS_ADDR(P_NBITS_ADDR),
    .P_NBITS_DATA(P_NBITS_DATA)
  ) u_ram (
    .clk    (clk),
    .wr_en  (we),
    .wr_addr(wr_addr_q),
    .wr_data(d),
    .rd_en  (issue),
    .rd_addr(rd_addr),
    .rd_data(ram_rdata)
  );

  assign rd.rd_valid = out_vld_q;
  assign rd.rd_data  = out_dat_q;
  assign rd.rd_last  = out_last_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule
